serial_alu_arbiter: RTL

Bit-serial add/subtract engine that shares a single `Full_adder` between two requesters. It arbitrates between the requesters round-robin and latches the winner's operands. It then sequences the operand bits LSB-first through the one adder cell, one bit per cycle, and returns a registered result with carry and overflow flags. It is the area-minimal arithmetic path of the 8-bit ALU, used where latency is cheaper than eight adder cells.

---
 rtl/alu_pkg.sv | 16 +
 rtl/Full_adder.sv | 13 +
 rtl/serial_alu_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared constants and state encoding for the bit-serial ALU path.
package alu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/Full_adder.sv
// Single-bit full adder cell shared by the serial datapath.
module Full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Carry
);

  assign Sum   = A ^ B ^ Cin;
  assign Carry = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_alu_arbiter.sv
// Round-robin arbitrated, bit-serial add/subtract engine built around one
// full-adder cell; one operation per WIDTH+2 cycles.
module serial_alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Req0,
  input  logic             Req1,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] B0,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  input  logic             Op0,
  input  logic             Op1,
  output logic             Gnt0,
  output logic             Gnt1,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             Cout,
  output logic             Ovf,
  output logic             Tag
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_t             state;
  state_t             state_next;
  logic               last;
  logic               idx;
  logic               grant;
  logic               gnt_idx;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   r_sh;
  logic               c;
  logic [CNT_W-1:0]   cnt;
  logic               last_bit;
  logic               fa_sum;
  logic               fa_carry;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic               sel_op;

  Full_adder u_fa (
    .A     (a_sh[0]),
    .B     (b_sh[0]),
    .Cin   (c),
    .Sum   (fa_sum),
    .Carry (fa_carry)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign Busy     = (state != IDLE);
  assign Done     = (state == DONE);
  assign sel_a    = (gnt_idx == REQ1) ? A1  : A0;
  assign sel_b    = (gnt_idx == REQ1) ? B1  : B0;
  assign sel_op   = (gnt_idx == REQ1) ? Op1 : Op0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Arbitration is only open in IDLE; on a tie the requester that did not win last time goes first.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    gnt_idx    = REQ0;
    Gnt0       = 1'b0;
    Gnt1       = 1'b0;
    case (state)
      IDLE: begin
        if (!rst && (Req0 || Req1)) begin
          grant      = 1'b1;
          gnt_idx    = (Req0 && Req1) ? ~last : (Req1 ? REQ1 : REQ0);
          Gnt0       = (gnt_idx == REQ0);
          Gnt1       = (gnt_idx == REQ1);
          state_next = RUN;
        end
      end
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last   <= REQ1;
      idx    <= REQ0;
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      c      <= 1'b0;
      cnt    <= '0;
      Result <= '0;
      Cout   <= 1'b0;
      Ovf    <= 1'b0;
      Tag    <= 1'b0;
    end else if (grant) begin
      // Subtract is A + ~B + 1: invert B here, carry-in supplies the +1.
      a_sh <= sel_a;
      b_sh <= sel_b ^ {WIDTH{sel_op}};
      c    <= sel_op;
      idx  <= gnt_idx;
      last <= gnt_idx;
      cnt  <= '0;
    end else if (state == RUN) begin
      c    <= fa_carry;
      r_sh <= {fa_sum, r_sh[WIDTH-1:1]};
      a_sh <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh <= {1'b0, b_sh[WIDTH-1:1]};
      cnt  <= cnt + CNT_W'(1);
      if (last_bit) begin
        Result <= {fa_sum, r_sh[WIDTH-1:1]};
        Cout   <= fa_carry;
        Ovf    <= c ^ fa_carry;
        Tag    <= idx;
      end
    end
  end

endmodule
